ts_packet_source: RTL and testbench



---
 rtl/dvbc_ts_pkg.sv | 30 +++
 rtl/ts_dpram.sv | 30 +++
 rtl/ts_packet_source.sv | 188 ++++++++++++++++++
 tb/tb_ts_packet_source.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvbc_ts_pkg.sv
// Shared constants and types for the DVB-C transport-stream front end.
// Combinational helpers only; no latency.
// No flow control lives here.
package dvbc_ts_pkg;

    localparam logic [7:0]  TS_SYNC  = 8'h47;
    // Null packet header: sync, PID 0x1FFF, payload-only with CC 0.
    localparam logic [31:0] NULL_HDR = {TS_SYNC, 8'h1F, 8'hFF, 8'h10};
    localparam logic [7:0]  STUFF    = 8'hFF;
    localparam logic [7:0]  CHK_FILL = 8'h00;
    localparam int          TS_LEN   = 188;
    localparam int          RS_LEN   = 204;

    typedef enum logic [0:0] {
        W_HUNT = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    // Byte of a null packet at slot index idx (header, then stuffing).
    function automatic logic [7:0] nullByte(input int unsigned idx);
        case (idx)
            0:       return NULL_HDR[31:24];
            1:       return NULL_HDR[23:16];
            2:       return NULL_HDR[15:8];
            3:       return NULL_HDR[7:0];
            default: return STUFF;
        endcase
    endfunction

endpackage

// File: rtl/ts_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid the cycle after iRe; write visible next cycle.
// No backpressure; output holds its last value while iRe is low.
// Ports: iClk clock; iWe/iWAddr/iWData write port; iRe/iRAddr read request;
//        oRData registered read data.
module ts_dpram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic                     iClk,
    input  logic                     iWe,
    input  logic [$clog2(DEPTH)-1:0] iWAddr,
    input  logic [DATA_W-1:0]        iWData,
    input  logic                     iRe,
    input  logic [$clog2(DEPTH)-1:0] iRAddr,
    output logic [DATA_W-1:0]        oRData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWAddr] <= iWData;
        end
        if (iRe) begin
            oRData <= mem[iRAddr];
        end
    end

endmodule

// File: rtl/ts_packet_source.sv
// Packet-aware TS byte FIFO that emits fixed-length slots (packet or null + check placeholders).
// Latency: output byte registered, 1 cycle after iReq; no bubbles on continuous iReq.
// Input is never stalled: bytes arriving while full are dropped and the partial packet is discarded.
// Ports: iClk/iClrn clock and async active-low reset; iData/iValid/iPsync byte input;
//        iReq byte request; iClrFlags clears sticky flags; oData/oValid/oPSync/oCheck output byte;
//        oLevel/oPkts/oFull/oEmpty FIFO status; oOverflow/oSyncErr sticky error flags.
module ts_packet_source
    import dvbc_ts_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int PKT_LEN  = TS_LEN,
    parameter int SLOT_LEN = RS_LEN
) (
    input  logic                   iClk,
    input  logic                   iClrn,
    input  logic [DATA_W-1:0]      iData,
    input  logic                   iValid,
    input  logic                   iPsync,
    input  logic                   iReq,
    input  logic                   iClrFlags,
    output logic [DATA_W-1:0]      oData,
    output logic                   oValid,
    output logic                   oPSync,
    output logic                   oCheck,
    output logic [$clog2(DEPTH):0] oLevel,
    output logic [$clog2(DEPTH):0] oPkts,
    output logic                   oFull,
    output logic                   oEmpty,
    output logic                   oOverflow,
    output logic                   oSyncErr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(PKT_LEN + 1);
    localparam int SW  = $clog2(SLOT_LEN);

    // write side
    wr_state_t      wrState, stateNext;
    logic [AW-1:0]  wptr, wptrNext, pktBase, baseNext, wrAddr;
    logic [WCW-1:0] wcnt, wcntNext;
    logic [CW-1:0]  level, pkts, discard;
    logic           wrEn, store, commit, ovfEvt, syncEvt, full;

    // read side
    logic [AW-1:0]     rptr;
    logic [SW-1:0]     sidx;
    logic              slotData, curData, inPkt, rdEn, rdDone, ramSel;
    logic [DATA_W-1:0] ramQ, constQ, constNext;

    assign full = (level == CW'(DEPTH));

    always_comb begin
        stateNext = wrState;
        wptrNext  = wptr;
        baseNext  = pktBase;
        wcntNext  = wcnt;
        wrAddr    = wptr;
        wrEn      = 1'b0;
        store     = 1'b0;
        commit    = 1'b0;
        ovfEvt    = 1'b0;
        syncEvt   = 1'b0;
        discard   = '0;
        if (iValid) begin
            if (full && (wrState == W_FILL || iPsync)) begin
                // Drop the byte and throw away whatever partial packet was in flight.
                ovfEvt    = 1'b1;
                wptrNext  = pktBase;
                discard   = (wrState == W_FILL) ? CW'(wcnt) : '0;
                wcntNext  = '0;
                stateNext = W_HUNT;
            end else if (wrState == W_HUNT) begin
                if (iPsync) begin
                    wrEn      = 1'b1;
                    store     = 1'b1;
                    wptrNext  = wptr + AW'(1);
                    wcntNext  = WCW'(1);
                    stateNext = W_FILL;
                end
            end else if (iPsync) begin
                // Early sync: the short packet is discarded and this byte starts a new one
                // at the same base address.
                syncEvt  = 1'b1;
                discard  = CW'(wcnt);
                wrEn     = 1'b1;
                store    = 1'b1;
                wrAddr   = pktBase;
                wptrNext = pktBase + AW'(1);
                wcntNext = WCW'(1);
            end else begin
                wrEn     = 1'b1;
                store    = 1'b1;
                wptrNext = wptr + AW'(1);
                wcntNext = wcnt + WCW'(1);
                if (wcnt == WCW'(PKT_LEN - 1)) begin
                    commit    = 1'b1;
                    baseNext  = wptr + AW'(1);
                    wcntNext  = '0;
                    stateNext = W_HUNT;
                end
            end
        end
    end

    // Slot mode is decided from the committed-packet count at index 0 and held afterwards.
    always_comb begin
        curData   = (sidx == '0) ? (pkts != '0) : slotData;
        inPkt     = (sidx < SW'(PKT_LEN));
        rdEn      = iReq & curData & inPkt;
        rdDone    = rdEn & (sidx == SW'(PKT_LEN - 1));
        constNext = inPkt ? DATA_W'(nullByte(32'(sidx))) : DATA_W'(CHK_FILL);
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            wrState   <= W_HUNT;
            wptr      <= '0;
            pktBase   <= '0;
            wcnt      <= '0;
            level     <= '0;
            pkts      <= '0;
            oOverflow <= 1'b0;
            oSyncErr  <= 1'b0;
        end else begin
            wrState   <= stateNext;
            wptr      <= wptrNext;
            pktBase   <= baseNext;
            wcnt      <= wcntNext;
            // Read space is released only once a whole packet has left.
            level     <= level - discard + CW'(store) - (rdDone ? CW'(PKT_LEN) : CW'(0));
            pkts      <= pkts + CW'(commit) - CW'(rdDone);
            oOverflow <= (oOverflow & ~iClrFlags) | ovfEvt;
            oSyncErr  <= (oSyncErr & ~iClrFlags) | syncEvt;
        end
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            sidx     <= '0;
            slotData <= 1'b0;
            rptr     <= '0;
            oValid   <= 1'b0;
            oPSync   <= 1'b0;
            oCheck   <= 1'b0;
            ramSel   <= 1'b0;
            constQ   <= '0;
        end else begin
            oValid <= iReq;
            oPSync <= iReq & (sidx == '0);
            oCheck <= iReq & ~inPkt;
            if (iReq) begin
                sidx   <= (sidx == SW'(SLOT_LEN - 1)) ? '0 : sidx + SW'(1);
                ramSel <= rdEn;
                constQ <= constNext;
                if (sidx == '0) begin
                    slotData <= curData;
                end
            end
            if (rdEn) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    // The RAM is addressed with rptr in the request cycle, so its registered output lines up
    // with the other registered outputs and continuous requests see no bubble.
    ts_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) uRam (
        .iClk   (iClk),
        .iWe    (wrEn),
        .iWAddr (wrAddr),
        .iWData (iData),
        .iRe    (rdEn),
        .iRAddr (rptr),
        .oRData (ramQ)
    );

    assign oData  = ramSel ? ramQ : constQ;
    assign oLevel = level;
    assign oPkts  = pkts;
    assign oFull  = full;
    assign oEmpty = (pkts == '0);

endmodule

// File: tb/tb_ts_packet_source.sv
// Directed bench for ts_packet_source: a 204-byte-slot instance and a 188-byte-slot streaming instance.
// Outputs are sampled 1 time unit after the rising edge.
// Requests and writes are driven without waiting on the DUT, so every run is bounded.
module tb_ts_packet_source;

    logic       clk = 1'b0;
    logic       clrn;
    always #5 clk = ~clk;

    // instance A: DEPTH 1024, SLOT_LEN 204
    logic [7:0]  data;
    logic        valid, psync, req, clrFlags;
    logic [7:0]  oData;
    logic        oValid, oPSync, oCheck, oFull, oEmpty, oOverflow, oSyncErr;
    logic [10:0] oLevel, oPkts;

    // instance B: DEPTH 512, SLOT_LEN 188
    logic [7:0]  data2;
    logic        valid2, psync2, req2, clrFlags2;
    logic [7:0]  oData2;
    logic        oValid2, oPSync2, oCheck2, oFull2, oEmpty2, oOverflow2, oSyncErr2;
    logic [9:0]  oLevel2, oPkts2;

    int vectors = 0;
    int errors  = 0;

    ts_packet_source #(.DATA_W(8), .DEPTH(1024), .PKT_LEN(188), .SLOT_LEN(204)) dut (
        .iClk(clk), .iClrn(clrn), .iData(data), .iValid(valid), .iPsync(psync),
        .iReq(req), .iClrFlags(clrFlags), .oData(oData), .oValid(oValid), .oPSync(oPSync),
        .oCheck(oCheck), .oLevel(oLevel), .oPkts(oPkts), .oFull(oFull), .oEmpty(oEmpty),
        .oOverflow(oOverflow), .oSyncErr(oSyncErr)
    );

    ts_packet_source #(.DATA_W(8), .DEPTH(512), .PKT_LEN(188), .SLOT_LEN(188)) dut2 (
        .iClk(clk), .iClrn(clrn), .iData(data2), .iValid(valid2), .iPsync(psync2),
        .iReq(req2), .iClrFlags(clrFlags2), .oData(oData2), .oValid(oValid2), .oPSync(oPSync2),
        .oCheck(oCheck2), .oLevel(oLevel2), .oPkts(oPkts2), .oFull(oFull2), .oEmpty(oEmpty2),
        .oOverflow(oOverflow2), .oSyncErr(oSyncErr2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packet byte i for a given seed: sync byte then an incrementing ramp.
    function automatic logic [7:0] pktByte(input int seed, input int i);
        logic [7:0] v;
        v = 8'((seed + i - 1) & 255);
        return (i == 0) ? 8'h47 : v;
    endfunction

    // Expected byte at slot index j of a 204-byte slot.
    function automatic logic [7:0] expByte(input int seed, input bit isData, input int j);
        if (j >= 188) return 8'h00;
        if (isData) return pktByte(seed, j);
        case (j)
            0:       return 8'h47;
            1:       return 8'h1F;
            2:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic writePkt(input int seed);
        for (int i = 0; i < 188; i++) begin
            data  = pktByte(seed, i);
            valid = 1'b1;
            psync = (i == 0);
            step();
        end
        valid = 1'b0;
        psync = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        #3;
        vectors++;
        if ({oValid, oPSync, oCheck, oData, oLevel, oPkts, oFull, oEmpty, oOverflow, oSyncErr}
            !== {3'b000, 8'h00, 11'd0, 11'd0, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_a: v=%b ps=%b ck=%b d=%h lvl=%0d pk=%0d f=%b e=%b ov=%b se=%b, want all 0 and e=1",
                     oValid, oPSync, oCheck, oData, oLevel, oPkts, oFull, oEmpty, oOverflow, oSyncErr);
        end
        vectors++;
        if ({oValid2, oLevel2, oPkts2, oEmpty2, oOverflow2, oSyncErr2} !== {1'b0, 10'd0, 10'd0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_b: v=%b lvl=%0d pk=%0d e=%b, want 0/0/0/1", oValid2, oLevel2, oPkts2, oEmpty2);
        end
        step();
        clrn = 1'b1;
        step();
    endtask

    task automatic test_null_slots();
        for (int k = 0; k < 408; k++) begin
            int j;
            j   = k % 204;
            req = 1'b1;
            step();
            vectors++;
            if ({oValid, oPSync, oCheck, oData} !== {1'b1, j == 0, j >= 188, expByte(0, 1'b0, j)}) begin
                errors++;
                $display("FAIL null_slot byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b %b %h",
                         k, oValid, oPSync, oCheck, oData, j == 0, j >= 188, expByte(0, 1'b0, j));
            end
        end
        req = 1'b0;
        step();
        vectors++;
        if ({oValid, oPkts, oLevel, oEmpty} !== {1'b0, 11'd0, 11'd0, 1'b1}) begin
            errors++;
            $display("FAIL null_idle: v=%b pk=%0d lvl=%0d e=%b, want 0 0 0 1", oValid, oPkts, oLevel, oEmpty);
        end
    endtask

    task automatic test_single_packet();
        writePkt(0);
        step();
        vectors++;
        if ({oPkts, oLevel, oEmpty} !== {11'd1, 11'd188, 1'b0}) begin
            errors++;
            $display("FAIL single_commit: pk=%0d lvl=%0d e=%b, want 1 188 0", oPkts, oLevel, oEmpty);
        end
        for (int k = 0; k < 408; k++) begin
            int  j;
            bit  isData;
            j      = k % 204;
            isData = (k < 204);
            req    = 1'b1;
            step();
            vectors++;
            if ({oValid, oPSync, oCheck, oData} !== {1'b1, j == 0, j >= 188, expByte(0, isData, j)}) begin
                errors++;
                $display("FAIL single_slot byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b %b %h",
                         k, oValid, oPSync, oCheck, oData, j == 0, j >= 188, expByte(0, isData, j));
            end
            if (k == 186 || k == 187) begin
                vectors++;
                if (oPkts !== ((k == 186) ? 11'd1 : 11'd0)) begin
                    errors++;
                    $display("FAIL single_pkts at byte %0d: got %0d, want %0d", k, oPkts, (k == 186) ? 1 : 0);
                end
            end
        end
        req = 1'b0;
        step();
        vectors++;
        if ({oPkts, oLevel} !== {11'd0, 11'd0}) begin
            errors++;
            $display("FAIL single_drain: pk=%0d lvl=%0d, want 0 0", oPkts, oLevel);
        end
    endtask

    task automatic test_sync_err();
        for (int i = 0; i < 100; i++) begin
            data  = pktByte(8'h80, i);
            valid = 1'b1;
            psync = (i == 0);
            step();
        end
        // Packet B starts at byte 100 of A, with a flag clear in the same cycle.
        for (int i = 0; i < 188; i++) begin
            data     = pktByte(8'h30, i);
            valid    = 1'b1;
            psync    = (i == 0);
            clrFlags = (i == 0);
            step();
            if (i == 0) begin
                vectors++;
                if ({oSyncErr, oLevel} !== {1'b1, 11'd1}) begin
                    errors++;
                    $display("FAIL sync_detect: se=%b lvl=%0d, want 1 1", oSyncErr, oLevel);
                end
            end
        end
        valid    = 1'b0;
        psync    = 1'b0;
        clrFlags = 1'b0;
        step();
        vectors++;
        if ({oSyncErr, oPkts, oLevel, oOverflow} !== {1'b1, 11'd1, 11'd188, 1'b0}) begin
            errors++;
            $display("FAIL sync_state: se=%b pk=%0d lvl=%0d ov=%b, want 1 1 188 0", oSyncErr, oPkts, oLevel, oOverflow);
        end
        // Read packet B with a request gap every 5th cycle; slot state must hold across gaps.
        for (int j = 0; j < 204; j++) begin
            if (j % 5 == 4) begin
                req = 1'b0;
                step();
                vectors++;
                if (oValid !== 1'b0) begin
                    errors++;
                    $display("FAIL sync_gap at byte %0d: oValid=%b, want 0", j, oValid);
                end
            end
            req = 1'b1;
            step();
            vectors++;
            if ({oValid, oPSync, oCheck, oData} !== {1'b1, j == 0, j >= 188, expByte(8'h30, 1'b1, j)}) begin
                errors++;
                $display("FAIL sync_slot byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b %b %h",
                         j, oValid, oPSync, oCheck, oData, j == 0, j >= 188, expByte(8'h30, 1'b1, j));
            end
        end
        req      = 1'b0;
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        vectors++;
        if ({oSyncErr, oPkts, oLevel} !== {1'b0, 11'd0, 11'd0}) begin
            errors++;
            $display("FAIL sync_clear: se=%b pk=%0d lvl=%0d, want 0 0 0", oSyncErr, oPkts, oLevel);
        end
    endtask

    task automatic test_overflow();
        for (int p = 1; p <= 5; p++) writePkt(p * 11);
        step();
        vectors++;
        if ({oPkts, oLevel, oFull, oOverflow} !== {11'd5, 11'd940, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_fill: pk=%0d lvl=%0d f=%b ov=%b, want 5 940 0 0", oPkts, oLevel, oFull, oOverflow);
        end
        for (int i = 0; i < 188; i++) begin
            data  = pktByte(8'h99, i);
            valid = 1'b1;
            psync = (i == 0);
            step();
            if (i == 83) begin
                vectors++;
                if ({oFull, oOverflow, oLevel} !== {1'b1, 1'b0, 11'd1024}) begin
                    errors++;
                    $display("FAIL ovf_full: f=%b ov=%b lvl=%0d, want 1 0 1024", oFull, oOverflow, oLevel);
                end
            end
            if (i == 84) begin
                vectors++;
                if ({oFull, oOverflow, oLevel, oPkts} !== {1'b0, 1'b1, 11'd940, 11'd5}) begin
                    errors++;
                    $display("FAIL ovf_drop: f=%b ov=%b lvl=%0d pk=%0d, want 0 1 940 5", oFull, oOverflow, oLevel, oPkts);
                end
            end
        end
        valid = 1'b0;
        psync = 1'b0;
        step();
        vectors++;
        if ({oOverflow, oLevel, oPkts} !== {1'b1, 11'd940, 11'd5}) begin
            errors++;
            $display("FAIL ovf_after: ov=%b lvl=%0d pk=%0d, want 1 940 5", oOverflow, oLevel, oPkts);
        end
        // Drain the five packets; their storage wraps past the end of the RAM.
        for (int k = 0; k < 5 * 204; k++) begin
            int j;
            int seed;
            j    = k % 204;
            seed = (k / 204 + 1) * 11;
            req  = 1'b1;
            step();
            vectors++;
            if ({oValid, oPSync, oCheck, oData} !== {1'b1, j == 0, j >= 188, expByte(seed, 1'b1, j)}) begin
                errors++;
                $display("FAIL ovf_drain byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b %b %h",
                         k, oValid, oPSync, oCheck, oData, j == 0, j >= 188, expByte(seed, 1'b1, j));
            end
        end
        req      = 1'b0;
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        vectors++;
        if ({oOverflow, oPkts, oLevel, oEmpty} !== {1'b0, 11'd0, 11'd0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_clear: ov=%b pk=%0d lvl=%0d e=%b, want 0 0 0 1", oOverflow, oPkts, oLevel, oEmpty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 188; i++) begin
            data2  = pktByte(7, i);
            valid2 = 1'b1;
            psync2 = (i == 0);
            step();
        end
        // Slot s outputs packet s while packet s+1 streams in; every slot must be DATA.
        for (int c = 0; c < 6 * 188; c++) begin
            int s;
            int j;
            s      = c / 188;
            j      = c % 188;
            req2   = 1'b1;
            data2  = pktByte((s + 1) * 23 + 7, j);
            valid2 = 1'b1;
            psync2 = (j == 0);
            step();
            vectors++;
            if ({oValid2, oPSync2, oCheck2, oData2} !== {1'b1, j == 0, 1'b0, pktByte(s * 23 + 7, j)}) begin
                errors++;
                $display("FAIL stream byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b 0 %h",
                         c, oValid2, oPSync2, oCheck2, oData2, j == 0, pktByte(s * 23 + 7, j));
            end
            if (c == 187) begin
                vectors++;
                if ({oPkts2, oLevel2} !== {10'd1, 10'd188}) begin
                    errors++;
                    $display("FAIL stream_commit_and_read: pk=%0d lvl=%0d, want 1 188", oPkts2, oLevel2);
                end
            end
        end
        req2   = 1'b0;
        valid2 = 1'b0;
        psync2 = 1'b0;
        step();
        vectors++;
        if ({oPkts2, oLevel2, oOverflow2, oSyncErr2} !== {10'd1, 10'd188, 2'b00}) begin
            errors++;
            $display("FAIL stream_end: pk=%0d lvl=%0d ov=%b se=%b, want 1 188 0 0", oPkts2, oLevel2, oOverflow2, oSyncErr2);
        end
    endtask

    task automatic test_reset_mid_slot();
        writePkt(8'h55);
        for (int j = 0; j < 50; j++) begin
            req = 1'b1;
            step();
            vectors++;
            if ({oValid, oData} !== {1'b1, pktByte(8'h55, j)}) begin
                errors++;
                $display("FAIL pre_reset byte %0d: got v=%b d=%h, want 1 %h", j, oValid, oData, pktByte(8'h55, j));
            end
        end
        req  = 1'b0;
        clrn = 1'b0;
        #2;
        vectors++;
        if ({oValid, oPSync, oCheck, oData, oLevel, oPkts, oFull, oEmpty, oOverflow, oSyncErr}
            !== {3'b000, 8'h00, 11'd0, 11'd0, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL mid_reset: v=%b d=%h lvl=%0d pk=%0d e=%b, want 0 00 0 0 1", oValid, oData, oLevel, oPkts, oEmpty);
        end
        step();
        clrn = 1'b1;
        step();
        for (int j = 0; j < 204; j++) begin
            req = 1'b1;
            step();
            vectors++;
            if ({oValid, oPSync, oCheck, oData} !== {1'b1, j == 0, j >= 188, expByte(0, 1'b0, j)}) begin
                errors++;
                $display("FAIL post_reset byte %0d: got v=%b ps=%b ck=%b d=%h, want 1 %b %b %h",
                         j, oValid, oPSync, oCheck, oData, j == 0, j >= 188, expByte(0, 1'b0, j));
            end
        end
        req = 1'b0;
        step();
    endtask

    initial begin
        data      = 8'h00;
        valid     = 1'b0;
        psync     = 1'b0;
        req       = 1'b0;
        clrFlags  = 1'b0;
        data2     = 8'h00;
        valid2    = 1'b0;
        psync2    = 1'b0;
        req2      = 1'b0;
        clrFlags2 = 1'b0;
        clrn      = 1'b1;
        #2;
        test_reset();
        test_null_slots();
        test_single_packet();
        test_sync_err();
        test_overflow();
        test_back_to_back();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
